// File: rtl/tank_game_engine.sv
// Two-player tank battle engine: tank movement, per-player bullet pools,
// firing on rising edges and hit detection, all published as 32-bit sprite words.
module tank_game_engine #(
    parameter int MAX_BULLETS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        game_on,
    input  logic        up1,
    input  logic        down1,
    input  logic        left1,
    input  logic        right1,
    input  logic        fire1,
    input  logic        up2,
    input  logic        down2,
    input  logic        left2,
    input  logic        right2,
    input  logic        fire2,
    output logic [31:0] tank_ram_data,
    output logic [31:0] oppo_ram_data,
    output logic [31:0] bullet_ram_data [0:2*MAX_BULLETS-1]
);
    localparam int NB = 2 * MAX_BULLETS;

    logic [31:0] r_tank, r_oppo;
    logic [31:0] r_bul [0:NB-1];
    logic        r_fire1_q, r_fire2_q;

    logic [31:0] w_tank_mv, w_oppo_mv, w_tank_nxt, w_oppo_nxt;
    logic [31:0] w_bul_nxt [0:NB-1];
    logic [32:0] w_res;
    logic        w_hit_tank, w_hit_oppo, w_spawn1, w_spawn2, w_found1, w_found2;
    logic        w_unused_video;

    // video_on only qualifies the renderer; the engine state never depends on it
    assign w_unused_video = video_on;

    // Move one tank 1 px in the highest-priority pressed direction; clamp and
    // cancel the move if it would overlap the other (active) tank.
    function automatic logic [31:0] f_tank_move(input logic [31:0] me, input logic [31:0] oth,
                                                input logic up, input logic dn,
                                                input logic lf, input logic rt);
        logic [10:0] x, y, nx, ny, ox, oy;
        logic [1:0]  d;
        x  = {1'b0, me[27:18]};
        y  = {1'b0, me[17:8]};
        ox = {1'b0, oth[27:18]};
        oy = {1'b0, oth[17:8]};
        nx = x;
        ny = y;
        d  = me[31:30];
        if (up) begin
            d = 2'd0;
            if (y != 11'd0) ny = y - 11'd1;
        end else if (dn) begin
            d = 2'd2;
            if (y < 11'd448) ny = y + 11'd1;
        end else if (lf) begin
            d = 2'd3;
            if (x != 11'd0) nx = x - 11'd1;
        end else if (rt) begin
            d = 2'd1;
            if (x < 11'd608) nx = x + 11'd1;
        end
        if (oth[28] && (nx < ox + 11'd32) && (ox < nx + 11'd32) &&
            (ny < oy + 11'd32) && (oy < ny + 11'd32)) begin
            nx = x;
            ny = y;
        end
        if (!me[28]) return me;
        return {d, 1'b0, 1'b1, nx[9:0], ny[9:0], 8'h00};
    endfunction

    // Advance one bullet 2 px; returns {hit, next word}. Signed math so a step
    // past 0 is seen as leaving the field rather than wrapping to 1023.
    function automatic logic [32:0] f_bullet(input logic [31:0] b, input logic [31:0] tgt);
        logic signed [11:0] bx, by, tx, ty;
        logic               out, hit;
        bx = $signed({2'b00, b[27:18]});
        by = $signed({2'b00, b[17:8]});
        tx = $signed({2'b00, tgt[27:18]});
        ty = $signed({2'b00, tgt[17:8]});
        case (b[31:30])
            2'd0:    by = by - 12'sd2;
            2'd1:    bx = bx + 12'sd2;
            2'd2:    by = by + 12'sd2;
            default: bx = bx - 12'sd2;
        endcase
        out = (bx < 12'sd0) || (bx > 12'sd636) || (by < 12'sd0) || (by > 12'sd476);
        hit = tgt[28] && (bx < tx + 12'sd32) && (tx < bx + 12'sd4) &&
              (by < ty + 12'sd32) && (ty < by + 12'sd4);
        if (!b[28]) return 33'd0;
        if (hit || out) return {hit, 32'd0};
        return {1'b0, b[31:28], bx[9:0], by[9:0], 8'h00};
    endfunction

    // Next-state for tanks and bullets: move, hit, then spawn into free slots
    always_comb begin
        w_hit_tank = 1'b0;
        w_hit_oppo = 1'b0;
        w_found1   = 1'b0;
        w_found2   = 1'b0;
        w_res      = 33'd0;
        w_tank_mv  = f_tank_move(r_tank, r_oppo, up1, down1, left1, right1);
        w_oppo_mv  = f_tank_move(r_oppo, r_tank, up2, down2, left2, right2);
        w_spawn1   = fire1 && !r_fire1_q && r_tank[28];
        w_spawn2   = fire2 && !r_fire2_q && r_oppo[28];
        for (int i = 0; i < NB; i++) begin
            w_res        = f_bullet(r_bul[i], (i < MAX_BULLETS) ? r_oppo : r_tank);
            w_bul_nxt[i] = w_res[31:0];
            if (i < MAX_BULLETS) w_hit_oppo = w_hit_oppo | w_res[32];
            else                 w_hit_tank = w_hit_tank | w_res[32];
        end
        for (int i = 0; i < MAX_BULLETS; i++) begin
            if (w_spawn1 && !w_found1 && !r_bul[i][28]) begin
                w_bul_nxt[i] = {w_tank_mv[31:30], 1'b0, 1'b1, w_tank_mv[27:18] + 10'd14,
                                w_tank_mv[17:8] + 10'd14, 8'h00};
                w_found1 = 1'b1;
            end
            if (w_spawn2 && !w_found2 && !r_bul[MAX_BULLETS+i][28]) begin
                w_bul_nxt[MAX_BULLETS+i] = {w_oppo_mv[31:30], 1'b1, 1'b1,
                                            w_oppo_mv[27:18] + 10'd14,
                                            w_oppo_mv[17:8] + 10'd14, 8'h00};
                w_found2 = 1'b1;
            end
        end
        w_tank_nxt     = w_tank_mv;
        w_tank_nxt[28] = w_tank_mv[28] & ~w_hit_tank;
        w_oppo_nxt     = w_oppo_mv;
        w_oppo_nxt[28] = w_oppo_mv[28] & ~w_hit_oppo;
    end

    // State register: fire history always samples, game words only when game_on
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tank    <= {2'd0, 1'b0, 1'b1, 10'd160, 10'd400, 8'h00};
            r_oppo    <= {2'd2, 1'b0, 1'b1, 10'd480, 10'd64, 8'h00};
            r_fire1_q <= 1'b0;
            r_fire2_q <= 1'b0;
            for (int i = 0; i < NB; i++) r_bul[i] <= 32'd0;
        end else begin
            r_fire1_q <= fire1;
            r_fire2_q <= fire2;
            if (game_on) begin
                r_tank <= w_tank_nxt;
                r_oppo <= w_oppo_nxt;
                for (int i = 0; i < NB; i++) r_bul[i] <= w_bul_nxt[i];
            end
        end
    end

    assign tank_ram_data   = r_tank;
    assign oppo_ram_data   = r_oppo;
    assign bullet_ram_data = r_bul;

endmodule

// File: tb/tb_tank_game_engine.sv
// Directed bench for tank_game_engine: reset, movement, firing, exit, hit, game_on gating.
module tb_tank_game_engine;
    logic        clk = 1'b0;
    logic        reset, video_on, game_on;
    logic        up1, down1, left1, right1, fire1;
    logic        up2, down2, left2, right2, fire2;
    logic [31:0] tank_w, oppo_w;
    logic [31:0] bul [0:15];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    tank_game_engine #(.MAX_BULLETS(8)) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .game_on(game_on),
        .up1(up1), .down1(down1), .left1(left1), .right1(right1), .fire1(fire1),
        .up2(up2), .down2(down2), .left2(left2), .right2(right2), .fire2(fire2),
        .tank_ram_data(tank_w), .oppo_ram_data(oppo_w), .bullet_ram_data(bul)
    );

    function automatic logic [31:0] mk(input int d, input int own, input int act,
                                       input int x, input int y);
        logic [1:0] dd;
        logic [9:0] xx, yy;
        dd = d[1:0];
        xx = x[9:0];
        yy = y[9:0];
        return {dd, own[0], act[0], xx, yy, 8'h00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        {up1, down1, left1, right1, fire1} = '0;
        {up2, down2, left2, right2, fire2} = '0;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int nz;
        game_on = 1'b1;
        video_on = 1'b0;
        do_reset();
        n_tests++;
        if (tank_w !== mk(0, 0, 1, 160, 400)) begin
            n_fail++; $display("FAIL reset_tank got=%h exp=%h", tank_w, mk(0, 0, 1, 160, 400));
        end
        n_tests++;
        if (oppo_w !== mk(2, 0, 1, 480, 64)) begin
            n_fail++; $display("FAIL reset_oppo got=%h exp=%h", oppo_w, mk(2, 0, 1, 480, 64));
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (bul[i] !== 32'd0) nz++;
        n_tests++;
        if (nz !== 0) begin
            n_fail++; $display("FAIL reset_bullets nonzero_words=%0d exp=0", nz);
        end
    endtask

    task automatic test_move();
        video_on = 1'b1;
        down1 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_tests++;
            if (tank_w !== mk(2, 0, 1, 160, 400 + i)) begin
                n_fail++; $display("FAIL move_down step=%0d got=%h exp=%h", i, tank_w, mk(2, 0, 1, 160, 400 + i));
            end
        end
        down1 = 1'b0;
        up1 = 1'b1;
        tick();
        up1 = 1'b0;
        n_tests++;
        if (tank_w !== mk(0, 0, 1, 160, 405)) begin
            n_fail++; $display("FAIL move_up got=%h exp=%h", tank_w, mk(0, 0, 1, 160, 405));
        end
    endtask

    task automatic test_fire();
        int nz;
        fire1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_tests++;
            if (bul[0] !== mk(0, 0, 1, 174, 419 - 2 * (k - 1))) begin
                n_fail++; $display("FAIL fire_b0 clk=%0d got=%h exp=%h", k, bul[0], mk(0, 0, 1, 174, 419 - 2 * (k - 1)));
            end
            nz = 0;
            for (int i = 1; i < 16; i++) if (bul[i] !== 32'd0) nz++;
            n_tests++;
            if (nz !== 0) begin
                n_fail++; $display("FAIL fire_others clk=%0d nonzero_words=%0d exp=0", k, nz);
            end
        end
        fire1 = 1'b0;
    endtask

    task automatic test_exit();
        int bad;
        bad = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bul[0] !== mk(0, 0, 1, 174, 401 - 2 * i)) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL exit_flight bad_steps=%0d exp=0 last=%h", bad, bul[0]);
        end
        tick();
        n_tests++;
        if (bul[0] !== 32'd0) begin
            n_fail++; $display("FAIL exit_clear got=%h exp=00000000", bul[0]);
        end
        n_tests++;
        if (tank_w !== mk(0, 0, 1, 160, 405)) begin
            n_fail++; $display("FAIL exit_tank got=%h exp=%h", tank_w, mk(0, 0, 1, 160, 405));
        end
    endtask

    task automatic test_hit();
        logic [31:0] prev, saved;
        logic        done;
        do_reset();
        n_tests++;
        if (tank_w !== mk(0, 0, 1, 160, 400)) begin
            n_fail++; $display("FAIL midgame_reset got=%h exp=%h", tank_w, mk(0, 0, 1, 160, 400));
        end
        left2 = 1'b1;
        for (int i = 0; i < 320; i++) tick();
        left2 = 1'b0;
        n_tests++;
        if (oppo_w !== mk(3, 0, 1, 160, 64)) begin
            n_fail++; $display("FAIL oppo_left got=%h exp=%h", oppo_w, mk(3, 0, 1, 160, 64));
        end
        up2 = 1'b1;
        for (int i = 0; i < 65; i++) tick();
        up2 = 1'b0;
        n_tests++;
        if (oppo_w !== mk(0, 0, 1, 160, 0)) begin
            n_fail++; $display("FAIL oppo_clamp got=%h exp=%h", oppo_w, mk(0, 0, 1, 160, 0));
        end
        fire1 = 1'b1;
        tick();
        fire1 = 1'b0;
        n_tests++;
        if (bul[0] !== mk(0, 0, 1, 174, 414)) begin
            n_fail++; $display("FAIL hit_spawn got=%h exp=%h", bul[0], mk(0, 0, 1, 174, 414));
        end
        prev = bul[0];
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (bul[0] === 32'd0) done = 1'b1;
            else prev = bul[0];
        end
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL hit_timeout bullet=%h exp=00000000", bul[0]);
        end
        n_tests++;
        if (prev !== mk(0, 0, 1, 174, 32)) begin
            n_fail++; $display("FAIL hit_first_overlap last_live=%h exp=%h", prev, mk(0, 0, 1, 174, 32));
        end
        n_tests++;
        if (oppo_w !== mk(0, 0, 0, 160, 0)) begin
            n_fail++; $display("FAIL hit_oppo got=%h exp=%h", oppo_w, mk(0, 0, 0, 160, 0));
        end
        saved = oppo_w;
        up2 = 1'b1;
        fire2 = 1'b1;
        tick();
        fire2 = 1'b0;
        tick();
        fire2 = 1'b1;
        tick();
        clr_in();
        n_tests++;
        if (oppo_w !== saved || bul[8] !== 32'd0) begin
            n_fail++; $display("FAIL dead_oppo got=%h b8=%h exp=%h b8=00000000", oppo_w, bul[8], saved);
        end
    endtask

    task automatic test_game_off();
        logic [31:0] t;
        t = tank_w;
        game_on = 1'b0;
        up1 = 1'b1;
        fire1 = 1'b1;
        tick();
        tick();
        n_tests++;
        if (tank_w !== t || bul[0] !== 32'd0) begin
            n_fail++; $display("FAIL off_hold tank=%h b0=%h exp=%h b0=00000000", tank_w, bul[0], t);
        end
        up1 = 1'b0;
        game_on = 1'b1;
        tick();
        n_tests++;
        if (tank_w !== t || bul[0] !== 32'd0) begin
            n_fail++; $display("FAIL on_no_spawn tank=%h b0=%h exp=%h b0=00000000", tank_w, bul[0], t);
        end
        fire1 = 1'b0;
        tick();
        fire1 = 1'b1;
        tick();
        fire1 = 1'b0;
        n_tests++;
        if (bul[0] !== mk(0, 0, 1, 174, 414)) begin
            n_fail++; $display("FAIL refire got=%h exp=%h", bul[0], mk(0, 0, 1, 174, 414));
        end
    endtask

    initial begin
        reset = 1'b0;
        game_on = 1'b1;
        video_on = 1'b0;
        clr_in();
        test_reset();
        test_move();
        test_fire();
        test_exit();
        test_hit();
        test_game_off();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
